instruction_sequencer: RTL

- Program buffer and issue controller that drives the cpu block's 32-bit current_instruction, one word per cycle.
- A host loads a short program through a valid/ready write port, then pulses start.
- The sequencer issues the words in order and stalls on TENSOR_CORE_OPERATE (inserts NOPs) until the tensor core reports completion.
- It then reports halted, or error on a timeout.

---
 rtl/cpu_isa_pkg.sv | 47 ++++
 rtl/program_buffer.sv | 27 ++
 rtl/instruction_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// CPU instruction-set constants, field helpers and the sequencer state encoding.
// Shared by the instruction sequencer and its program buffer.
package cpu_isa_pkg;

  localparam logic [7:0] OP_ADD                 = 8'h00;
  localparam logic [7:0] OP_SUB                 = 8'h01;
  localparam logic [7:0] OP_MUL                 = 8'h02;
  localparam logic [7:0] OP_DIV                 = 8'h03;
  localparam logic [7:0] OP_WRITE_TENSOR_CORE   = 8'h04;
  localparam logic [7:0] OP_TENSOR_CORE_OPERATE = 8'h05;
  localparam logic [7:0] OP_LOAD                = 8'h06;
  localparam logic [7:0] OP_STORE               = 8'h07;
  localparam logic [7:0] OP_NOP                 = 8'h08;
  localparam logic [7:0] OP_AND                 = 8'h09;
  localparam logic [7:0] OP_OR                  = 8'h0A;
  localparam logic [7:0] OP_MOV                 = 8'h0B;
  localparam logic [7:0] OP_CMP                 = 8'h0C;
  localparam logic [7:0] OP_RESET               = 8'h0D;
  localparam logic [7:0] OP_JMP                 = 8'h0E;
  localparam logic [7:0] OP_READ_TENSOR_CORE    = 8'h0F;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0008;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_TC = 2'd2,
    DONE    = 2'd3
  } sequencer_state_t;

  function automatic logic [7:0] instr_dest(input logic [31:0] instr);
    return instr[31:24];
  endfunction

  function automatic logic [7:0] instr_src1(input logic [31:0] instr);
    return instr[23:16];
  endfunction

  function automatic logic [7:0] instr_src2(input logic [31:0] instr);
    return instr[15:8];
  endfunction

  function automatic logic [7:0] instr_opcode(input logic [31:0] instr);
    return instr[7:0];
  endfunction

endpackage

// File: rtl/program_buffer.sv
// DEPTH x 32 program store: one synchronous write port, combinational read port.
// Contents are intentionally not reset; the sequencer's length register bounds valid words.
module program_buffer
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instruction_sequencer.sv
// Loads a short program from the host, then issues one word per cycle to the cpu,
// holding NOPs while a TENSOR_CORE_OPERATE runs and flagging a sticky timeout error.
module instruction_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TC_TIMEOUT = 64,
  parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 program_write_valid_in,
  input  logic [31:0]          program_write_data_in,
  output logic                 program_write_ready_out,
  input  logic                 start_in,
  input  logic                 tensor_core_done_in,
  output logic [31:0]          current_instruction_out,
  output logic [PTR_WIDTH-1:0] program_counter_out,
  output logic [PTR_WIDTH-1:0] program_length_out,
  output logic                 busy_out,
  output logic                 halted_out,
  output logic                 error_out
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(TC_TIMEOUT + 1);

  sequencer_state_t       state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [PTR_WIDTH-1:0]   pc_q, pc_d;
  logic [PTR_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   tc_cnt_q, tc_cnt_d;
  logic                   err_q, err_d;

  logic                   wr_fire;
  logic [31:0]            rd_word;

  assign program_write_ready_out = (state_q == IDLE) && (len_q < PTR_WIDTH'(DEPTH));
  assign wr_fire                 = program_write_valid_in && program_write_ready_out;

  program_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_program_buffer (
    .clk_i     (clock_in),
    .wr_en_i   (wr_fire),
    .wr_addr_i (len_q[ADDR_WIDTH-1:0]),
    .wr_data_i (program_write_data_in),
    .rd_addr_i (pc_q[ADDR_WIDTH-1:0]),
    .rd_data_o (rd_word)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    len_d    = len_q;
    tc_cnt_d = tc_cnt_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        instr_d = NOP_INSTRUCTION;
        if (wr_fire) begin
          len_d = len_q + 1'b1;
        end
        // A word accepted alongside start is already counted in len_d.
        if (start_in) begin
          pc_d    = '0;
          state_d = (len_d == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        if (pc_q < len_q) begin
          instr_d = rd_word;
          pc_d    = pc_q + 1'b1;
          if (instr_opcode(rd_word) == OP_TENSOR_CORE_OPERATE) begin
            state_d  = WAIT_TC;
            tc_cnt_d = '0;
          end else if (pc_d == len_q) begin
            state_d = DONE;
          end
        end else begin
          instr_d = NOP_INSTRUCTION;
          state_d = DONE;
        end
      end

      WAIT_TC: begin
        instr_d = NOP_INSTRUCTION;
        // Done wins over a timeout landing on the same edge.
        if (tensor_core_done_in) begin
          state_d = (pc_q < len_q) ? RUN : DONE;
        end else begin
          tc_cnt_d = tc_cnt_q + 1'b1;
          if (tc_cnt_d == CNT_WIDTH'(TC_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        instr_d = NOP_INSTRUCTION;
        if (start_in) begin
          pc_d = '0;
          if (len_q != '0) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = IDLE;
        instr_d = NOP_INSTRUCTION;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      instr_q  <= NOP_INSTRUCTION;
      pc_q     <= '0;
      len_q    <= '0;
      tc_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      tc_cnt_q <= tc_cnt_d;
      err_q    <= err_d;
    end
  end

  assign current_instruction_out = instr_q;
  assign program_counter_out     = pc_q;
  assign program_length_out      = len_q;
  assign busy_out                = (state_q == RUN) || (state_q == WAIT_TC);
  assign halted_out              = (state_q == DONE);
  assign error_out               = err_q;

endmodule
